// File: rtl/tlbread_arbiter.sv
// tlbread_arbiter: shares the single TLB data-read port between the split-read
// unit (A, high priority) and the secondary microcode reader (B). Ownership is
// granted for a whole access, so split halves and locked RMW sequences never
// interleave with the other requester. B is forced through after STARVE_LIMIT
// consecutive A grants taken while B was waiting.
module tlbread_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_reset,

    input  logic        a_do,
    input  logic [1:0]  a_cpl,
    input  logic [31:0] a_address,
    input  logic [3:0]  a_length,
    input  logic [3:0]  a_length_full,
    input  logic        a_lock,
    input  logic        a_rmw,
    output logic        a_done,
    output logic        a_page_fault,
    output logic        a_ac_fault,
    output logic        a_retry,
    output logic [63:0] a_data,

    input  logic        b_do,
    input  logic [1:0]  b_cpl,
    input  logic [31:0] b_address,
    input  logic [3:0]  b_length,
    input  logic [3:0]  b_length_full,
    input  logic        b_lock,
    input  logic        b_rmw,
    output logic        b_done,
    output logic        b_page_fault,
    output logic        b_ac_fault,
    output logic        b_retry,
    output logic [63:0] b_data,

    output logic        grant_a,
    output logic        grant_b,

    output logic        tlbread_do,
    output logic [1:0]  tlbread_cpl,
    output logic [31:0] tlbread_address,
    output logic [3:0]  tlbread_length,
    output logic [3:0]  tlbread_length_full,
    output logic        tlbread_lock,
    output logic        tlbread_rmw,
    input  logic        tlbread_done,
    input  logic        tlbread_page_fault,
    input  logic        tlbread_ac_fault,
    input  logic        tlbread_retry,
    input  logic [63:0] tlbread_data
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    typedef struct packed {
        logic [1:0]  cpl;
        logic [31:0] address;
        logic [3:0]  length;
        logic [3:0]  length_full;
        logic        lock;
        logic        rmw;
    } rd_req_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t     state, state_d;
    logic       lock_hold;
    logic [2:0] starve_cnt;
    rd_req_t    req_a, req_b, req_sel;
    logic       in_own, own_lock, any_fault;

    assign req_a = '{a_cpl, a_address, a_length, a_length_full, a_lock, a_rmw};
    assign req_b = '{b_cpl, b_address, b_length, b_length_full, b_lock, b_rmw};

    // Field mux defaults to A so the TLB sees stable A fields while idle.
    assign req_sel  = (state == OWN_B) ? req_b : req_a;
    assign in_own   = (state != IDLE);
    assign own_lock = req_sel.lock;
    assign any_fault = tlbread_page_fault | tlbread_ac_fault;

    assign grant_a = (state == OWN_A);
    assign grant_b = (state == OWN_B);

    // Next-state: arbitrate from IDLE, release only when owner idle and not locked.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (!rd_reset) begin
                    if (a_do && b_do)
                        state_d = (starve_cnt == LIMIT) ? OWN_B : OWN_A;
                    else if (a_do)
                        state_d = OWN_A;
                    else if (b_do)
                        state_d = OWN_B;
                end
            end
            OWN_A:   if (!a_do && !lock_hold) state_d = IDLE;
            OWN_B:   if (!b_do && !lock_hold) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, lock hold and starvation counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lock_hold  <= 1'b0;
            starve_cnt <= 3'd0;
        end else begin
            state <= state_d;

            // A fault or an unlocked completed beat ends the locked sequence.
            if (rd_reset || (in_own && (any_fault || (tlbread_done && !own_lock))))
                lock_hold <= 1'b0;
            else if (in_own && own_lock && tlbread_do)
                lock_hold <= 1'b1;

            if (rd_reset)
                starve_cnt <= 3'd0;
            else if (state == IDLE && state_d == OWN_B)
                starve_cnt <= 3'd0;
            else if (state == IDLE && state_d == OWN_A) begin
                if (!b_do)
                    starve_cnt <= 3'd0;
                else if (starve_cnt != LIMIT)
                    starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

    // TLB request and response routing: only the owner talks to the TLB.
    always_comb begin
        tlbread_do   = 1'b0;
        a_done       = 1'b0;
        a_page_fault = 1'b0;
        a_ac_fault   = 1'b0;
        a_retry      = 1'b0;
        b_done       = 1'b0;
        b_page_fault = 1'b0;
        b_ac_fault   = 1'b0;
        b_retry      = 1'b0;
        if (state == OWN_A) begin
            tlbread_do   = a_do;
            a_done       = tlbread_done;
            a_page_fault = tlbread_page_fault;
            a_ac_fault   = tlbread_ac_fault;
            a_retry      = tlbread_retry;
        end else if (state == OWN_B) begin
            tlbread_do   = b_do;
            b_done       = tlbread_done;
            b_page_fault = tlbread_page_fault;
            b_ac_fault   = tlbread_ac_fault;
            b_retry      = tlbread_retry;
        end
    end

    assign tlbread_cpl         = req_sel.cpl;
    assign tlbread_address     = req_sel.address;
    assign tlbread_length      = req_sel.length;
    assign tlbread_length_full = req_sel.length_full;
    assign tlbread_lock        = req_sel.lock;
    assign tlbread_rmw         = req_sel.rmw;

    // Read data is broadcast; consumers qualify it with their own done.
    assign a_data = tlbread_data;
    assign b_data = tlbread_data;

endmodule

// File: tb/tb_tlbread_arbiter.sv
// Scoreboard bench for tlbread_arbiter: expected grant order and expected
// done/data deliveries are queued as stimulus is driven and checked when the
// DUT raises a grant or a done.
module tb_tlbread_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, rd_reset;
    logic        a_do, a_lock, a_rmw, b_do, b_lock, b_rmw;
    logic [1:0]  a_cpl, b_cpl;
    logic [31:0] a_address, b_address;
    logic [3:0]  a_length, a_length_full, b_length, b_length_full;
    logic        a_done, a_page_fault, a_ac_fault, a_retry;
    logic        b_done, b_page_fault, b_ac_fault, b_retry;
    logic [63:0] a_data, b_data;
    logic        grant_a, grant_b;
    logic        tlbread_do, tlbread_lock, tlbread_rmw;
    logic [1:0]  tlbread_cpl;
    logic [31:0] tlbread_address;
    logic [3:0]  tlbread_length, tlbread_length_full;
    logic        tlbread_done, tlbread_page_fault, tlbread_ac_fault, tlbread_retry;
    logic [63:0] tlbread_data;

    int n_checks = 0;
    int n_errors = 0;

    bit          exp_grant[$];   // 0 = A, 1 = B
    bit          exp_owner[$];
    logic [63:0] exp_data[$];
    bit          prev_ga = 1'b0, prev_gb = 1'b0;

    tlbread_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .rd_reset(rd_reset),
        .a_do(a_do), .a_cpl(a_cpl), .a_address(a_address), .a_length(a_length),
        .a_length_full(a_length_full), .a_lock(a_lock), .a_rmw(a_rmw),
        .a_done(a_done), .a_page_fault(a_page_fault), .a_ac_fault(a_ac_fault),
        .a_retry(a_retry), .a_data(a_data),
        .b_do(b_do), .b_cpl(b_cpl), .b_address(b_address), .b_length(b_length),
        .b_length_full(b_length_full), .b_lock(b_lock), .b_rmw(b_rmw),
        .b_done(b_done), .b_page_fault(b_page_fault), .b_ac_fault(b_ac_fault),
        .b_retry(b_retry), .b_data(b_data),
        .grant_a(grant_a), .grant_b(grant_b),
        .tlbread_do(tlbread_do), .tlbread_cpl(tlbread_cpl),
        .tlbread_address(tlbread_address), .tlbread_length(tlbread_length),
        .tlbread_length_full(tlbread_length_full), .tlbread_lock(tlbread_lock),
        .tlbread_rmw(tlbread_rmw), .tlbread_done(tlbread_done),
        .tlbread_page_fault(tlbread_page_fault), .tlbread_ac_fault(tlbread_ac_fault),
        .tlbread_retry(tlbread_retry), .tlbread_data(tlbread_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for either grant to be present.
    task automatic wait_grant;
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant_a || grant_b) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", 64'd0, 64'd1);
    endtask

    // One TLB beat completed for the expected owner.
    task automatic beat(input bit owner_b, input logic [63:0] d);
        exp_owner.push_back(owner_b);
        exp_data.push_back(d);
        tlbread_done = 1'b1;
        tlbread_data = d;
        tick();
        tlbread_done = 1'b0;
    endtask

    // Monitor: check grant order and done routing against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((grant_a && !prev_ga) || (grant_b && !prev_gb)) begin
                if (exp_grant.size() == 0)
                    chk("unexpected_grant", {63'd0, grant_b}, 64'd2);
                else
                    chk("grant_order", {63'd0, grant_b}, {63'd0, exp_grant.pop_front()});
            end
            if (a_done || b_done) begin
                chk("done_exclusive", {63'd0, a_done & b_done}, 64'd0);
                if (exp_owner.size() == 0)
                    chk("unexpected_done", {63'd0, b_done}, 64'd2);
                else begin
                    chk("done_owner", {63'd0, b_done}, {63'd0, exp_owner[0]});
                    chk("done_data", exp_owner[0] ? b_data : a_data, exp_data[0]);
                    void'(exp_owner.pop_front());
                    void'(exp_data.pop_front());
                end
            end
            prev_ga = grant_a;
            prev_gb = grant_b;
        end
    end

    initial begin
        rst_n = 1'b0; rd_reset = 1'b0;
        a_do = 0; a_lock = 0; a_rmw = 0; a_cpl = 2'd0; a_length = 4'd0; a_length_full = 4'd0;
        b_do = 0; b_lock = 0; b_rmw = 0; b_cpl = 2'd3; b_length = 4'd8; b_length_full = 4'd8;
        a_address = 32'hAAAA_0000; b_address = 32'hBBBB_0000;
        tlbread_done = 0; tlbread_page_fault = 0; tlbread_ac_fault = 0; tlbread_retry = 0;
        tlbread_data = 64'd0;
        repeat (3) tick();
        // Reset state
        chk("rst_grant_a", {63'd0, grant_a}, 64'd0);
        chk("rst_grant_b", {63'd0, grant_b}, 64'd0);
        chk("rst_tlb_do", {63'd0, tlbread_do}, 64'd0);
        chk("rst_addr_mux_a", {32'd0, tlbread_address}, 64'hAAAA_0000);
        chk("rst_starve", {61'd0, dut.starve_cnt}, 64'd0);
        rst_n = 1'b1;
        tick();

        // A only
        a_address = 32'h1000; a_length = 4'd4; a_length_full = 4'd4; a_do = 1'b1;
        exp_grant.push_back(1'b0);
        tick();
        chk("a_only_grant", {63'd0, grant_a}, 64'd1);
        chk("a_only_addr", {32'd0, tlbread_address}, 64'h1000);
        chk("a_only_len", {60'd0, tlbread_length}, 64'd4);
        chk("a_only_tlb_do", {63'd0, tlbread_do}, 64'd1);
        beat(1'b0, 64'h1111_2222_3333_4444);
        a_do = 1'b0;
        tick();
        chk("a_only_release", {63'd0, grant_a}, 64'd0);

        // Split read with B waiting
        a_length = 4'd4; a_length_full = 4'd8; a_do = 1'b1; b_do = 1'b1;
        exp_grant.push_back(1'b0);
        wait_grant();
        beat(1'b0, 64'h0000_0000_AAAA_0001);
        tick();
        chk("split_hold_b_mid", {63'd0, grant_b}, 64'd0);
        beat(1'b0, 64'h0000_0000_AAAA_0002);
        chk("split_hold_b_end", {63'd0, grant_b}, 64'd0);
        a_do = 1'b0;
        exp_grant.push_back(1'b1);
        wait_grant();
        chk("split_b_after", {63'd0, grant_b}, 64'd1);
        beat(1'b1, 64'hBBBB_0000_0000_0001);
        b_do = 1'b0;
        tick();

        // Five contended rounds: A,A,A,A,B then A once B leaves
        a_do = 1'b1; b_do = 1'b1;
        for (int r = 0; r < 5; r++) begin
            exp_grant.push_back(r == 4);
            wait_grant();
            if (grant_b) begin
                chk("starve_clr", {61'd0, dut.starve_cnt}, 64'd0);
                beat(1'b1, 64'hB000 + 64'(r));
                b_do = 1'b0;
            end else begin
                beat(1'b0, 64'hA000 + 64'(r));
                a_do = 1'b0;
                tick();
                a_do = 1'b1;
            end
        end
        exp_grant.push_back(1'b0);
        wait_grant();
        chk("round_tail_a", {63'd0, grant_a}, 64'd1);
        a_do = 1'b0;
        tick();

        // Locked RMW keeps ownership across idle cycles
        a_do = 1'b1; a_lock = 1'b1; a_rmw = 1'b1; b_do = 1'b1;
        exp_grant.push_back(1'b0);
        wait_grant();
        beat(1'b0, 64'h10C0_0001);
        a_do = 1'b0; a_lock = 1'b0; a_rmw = 1'b0;
        tick(); tick();
        chk("lock_keep_a", {63'd0, grant_a}, 64'd1);
        chk("lock_no_b", {63'd0, grant_b}, 64'd0);
        chk("lock_hold_set", {63'd0, dut.lock_hold}, 64'd1);
        a_do = 1'b1;
        beat(1'b0, 64'h10C0_0002);
        a_do = 1'b0;
        exp_grant.push_back(1'b1);
        wait_grant();
        chk("lock_then_b", {63'd0, grant_b}, 64'd1);

        // Page fault while B owns with lock held
        b_lock = 1'b1;
        beat(1'b1, 64'hFA17_0001);
        chk("fault_lock_pre", {63'd0, dut.lock_hold}, 64'd1);
        tlbread_page_fault = 1'b1;
        #4;
        chk("fault_b_pf", {63'd0, b_page_fault}, 64'd1);
        chk("fault_a_pf", {63'd0, a_page_fault}, 64'd0);
        tick();
        tlbread_page_fault = 1'b0;
        chk("fault_lock_clr", {63'd0, dut.lock_hold}, 64'd0);
        b_do = 1'b0; b_lock = 1'b0;
        tick();
        chk("fault_release", {63'd0, grant_b}, 64'd0);

        // rd_reset in OWN_A with lock_hold=1 and starve_cnt=3
        a_do = 1'b1; b_do = 1'b1;
        for (int r = 0; r < 3; r++) begin
            exp_grant.push_back(1'b0);
            wait_grant();
            if (r < 2) begin
                a_do = 1'b0;
                tick();
                a_do = 1'b1;
            end
        end
        a_lock = 1'b1;
        beat(1'b0, 64'h5EED_0003);
        chk("rdr_pre_cnt", {61'd0, dut.starve_cnt}, 64'd3);
        chk("rdr_pre_lock", {63'd0, dut.lock_hold}, 64'd1);
        rd_reset = 1'b1;
        tick();
        rd_reset = 1'b0;
        chk("rdr_lock_clr", {63'd0, dut.lock_hold}, 64'd0);
        chk("rdr_cnt_clr", {61'd0, dut.starve_cnt}, 64'd0);
        chk("rdr_grant_kept", {63'd0, grant_a}, 64'd1);
        a_do = 1'b0; a_lock = 1'b0;
        exp_grant.push_back(1'b1);
        wait_grant();
        chk("rdr_then_b", {63'd0, grant_b}, 64'd1);
        b_do = 1'b0;
        tick();

        // rd_reset in IDLE blocks a grant; then done and a_do fall together
        a_do = 1'b1; rd_reset = 1'b1;
        tick();
        chk("rdr_idle_block", {63'd0, grant_a}, 64'd0);
        rd_reset = 1'b0;
        exp_grant.push_back(1'b0);
        wait_grant();
        a_do = 1'b0;
        beat(1'b0, 64'hD0D0_0001);
        chk("same_edge_release", {63'd0, grant_a}, 64'd0);
        tick();

        chk("grant_q_empty", 64'(exp_grant.size()), 64'd0);
        chk("done_q_empty", 64'(exp_owner.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
